// File: rtl/core_pipe_decode_imm_stage_if.sv
// Handshake bundle for the immediate decode stage: an instruction/format
// request channel in, and a decoded-immediate response channel out.
interface core_pipe_decode_imm_stage_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [4:0]      in_fmt;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
  logic [4:0]      out_fmt;

  // Upstream fetch/align and downstream dispatch side of the stage
  modport master (
    output flush,
    output in_valid,
    input  in_ready,
    output in_instr,
    output in_fmt,
    input  out_valid,
    output out_ready,
    input  out_imm,
    input  out_illegal,
    input  out_fmt
  );

  // The decode stage itself
  modport slave (
    input  flush,
    input  in_valid,
    output in_ready,
    input  in_instr,
    input  in_fmt,
    output out_valid,
    input  out_ready,
    output out_imm,
    output out_illegal,
    output out_fmt
  );
endinterface

// File: rtl/core_pipe_decode_imm_stage.sv
// Pipelined immediate decoder: combinational RV32/RV64/RVC immediate decode
// feeding a small FIFO skid buffer with valid/ready flow control and flush.
// The interface instance must be built with the same XLEN as this module.
module core_pipe_decode_imm_stage #(
  parameter int XLEN       = 64,
  parameter int SKID_DEPTH = 2
) (
  input logic                        g_clk,
  input logic                        g_reset,
  core_pipe_decode_imm_stage_if.slave bus
);

  typedef enum logic [4:0] {
    FMT_I          = 5'd0,
    FMT_S          = 5'd1,
    FMT_B          = 5'd2,
    FMT_U          = 5'd3,
    FMT_J          = 5'd4,
    FMT_CSR_ZIMM   = 5'd5,
    FMT_C_ADDI16SP = 5'd6,
    FMT_C_ADDI4SPN = 5'd7,
    FMT_C_LSW      = 5'd8,
    FMT_C_ADDI     = 5'd9,
    FMT_C_LUI      = 5'd10,
    FMT_C_SHAMT    = 5'd11,
    FMT_C_LWSP     = 5'd12,
    FMT_C_SWSP     = 5'd13,
    FMT_C_J        = 5'd14,
    FMT_C_BZ       = 5'd15,
    FMT_C_LSD      = 5'd16,
    FMT_C_LDSP     = 5'd17,
    FMT_C_SDSP     = 5'd18
  } imm_fmt_e;

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SKID_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(SKID_DEPTH);

  logic [31:0]      ins;
  logic [63:0]      imm_full;
  logic             illegal;

  logic [XLEN-1:0]  imm_mem [SKID_DEPTH];
  logic             ill_mem [SKID_DEPTH];
  logic [4:0]       fmt_mem [SKID_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             out_valid;
  logic             push;
  logic             pop;

  assign ins = bus.in_instr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Decode the immediate at full 64-bit width; the buffer keeps the low XLEN bits
  always_comb begin
    imm_full = '0;
    illegal  = 1'b0;
    case (bus.in_fmt)
      FMT_I:        imm_full = {{52{ins[31]}}, ins[31:20]};
      FMT_S:        imm_full = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:        imm_full = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:        imm_full = {{32{ins[31]}}, ins[31:12], 12'b0};
      FMT_J:        imm_full = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_CSR_ZIMM: imm_full = {59'b0, ins[19:15]};
      FMT_C_ADDI16SP: begin
        imm_full = {{54{ins[12]}}, ins[12], ins[4:3], ins[5], ins[2], ins[6], 4'b0};
        illegal  = (imm_full == '0);
      end
      FMT_C_ADDI4SPN: begin
        imm_full = {54'b0, ins[10:7], ins[12:11], ins[5], ins[6], 2'b0};
        illegal  = (imm_full == '0);
      end
      FMT_C_LSW:    imm_full = {57'b0, ins[5], ins[12:10], ins[6], 2'b0};
      FMT_C_ADDI:   imm_full = {{58{ins[12]}}, ins[12], ins[6:2]};
      FMT_C_LUI: begin
        imm_full = {{46{ins[12]}}, ins[12], ins[6:2], 12'b0};
        illegal  = (imm_full == '0);
      end
      FMT_C_SHAMT: begin
        // shamt[5] only exists on RV64; on RV32 a set bit 12 is reserved
        if (XLEN == 64) begin
          imm_full = {58'b0, ins[12], ins[6:2]};
        end else begin
          imm_full = {59'b0, ins[6:2]};
          illegal  = ins[12];
        end
      end
      FMT_C_LWSP:   imm_full = {56'b0, ins[3:2], ins[12], ins[6:4], 2'b0};
      FMT_C_SWSP:   imm_full = {56'b0, ins[8:7], ins[12:9], 2'b0};
      FMT_C_J:      imm_full = {{52{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6], ins[7],
                                ins[2], ins[11], ins[5:3], 1'b0};
      FMT_C_BZ:     imm_full = {{55{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10],
                                ins[4:3], 1'b0};
      FMT_C_LSD, FMT_C_LDSP, FMT_C_SDSP: begin
        // Doubleword compressed forms are RV64-only
        if (XLEN == 64) begin
          if (bus.in_fmt == FMT_C_LSD) begin
            imm_full = {56'b0, ins[6:5], ins[12:10], 3'b0};
          end else if (bus.in_fmt == FMT_C_LDSP) begin
            imm_full = {55'b0, ins[4:2], ins[12], ins[6:5], 3'b0};
          end else begin
            imm_full = {55'b0, ins[9:7], ins[12:10], 3'b0};
          end
        end else begin
          imm_full = '0;
          illegal  = 1'b1;
        end
      end
      default: begin
        imm_full = '0;
        illegal  = 1'b1;
      end
    endcase
  end

  assign out_valid = (count != '0);
  assign push      = bus.in_valid & bus.in_ready;
  assign pop       = out_valid & bus.out_ready;

  // Occupancy for next cycle; flush empties the buffer and overrides push/pop
  always_comb begin
    count_next = count;
    if (bus.flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (bus.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
      end
    end
  end

  // Entry storage; contents are never observed while the entry is not valid
  always_ff @(posedge g_clk) begin
    if (push && !bus.flush) begin
      imm_mem[wr_ptr] <= imm_full[XLEN-1:0];
      ill_mem[wr_ptr] <= illegal;
      fmt_mem[wr_ptr] <= bus.in_fmt;
    end
  end

  // Head drives the outputs; an empty buffer presents all-zero outputs
  assign bus.out_valid   = out_valid;
  assign bus.out_imm     = out_valid ? imm_mem[rd_ptr] : '0;
  assign bus.out_illegal = out_valid ? ill_mem[rd_ptr] : 1'b0;
  assign bus.out_fmt     = out_valid ? fmt_mem[rd_ptr] : 5'd0;

  generate
    if (SKID_DEPTH == 1) begin : g_plain_reg
      // A single register can refill in the same cycle it drains
      assign bus.in_ready = ~out_valid | bus.out_ready;
    end else begin : g_skid
      logic in_ready_q;

      // Registered ready keeps the upstream timing path short
      always_ff @(posedge g_clk) begin
        if (g_reset) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (count_next < DEPTH_CNT);
        end
      end

      assign bus.in_ready = in_ready_q;
    end
  endgenerate

endmodule

// File: tb/tb_core_pipe_decode_imm_stage.sv
// Self-checking bench: an RV64 and an RV32 stage driven with identical
// stimulus, compared every cycle against an arithmetic decode model and a
// queue model of the two-entry buffer.
module tb_core_pipe_decode_imm_stage;

  logic        g_clk;
  logic        g_reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [4:0]  in_fmt;
  logic        out_ready;

  int tests_run    = 0;
  int tests_failed = 0;
  int dut_accepts  = 0;
  int dut_out_cycles = 0;

  typedef struct packed {
    logic [63:0] imm64;
    logic        ill64;
    logic [63:0] imm32;
    logic        ill32;
    logic [4:0]  fmt;
  } exp_entry_t;

  exp_entry_t model_q[$];

  core_pipe_decode_imm_stage_if #(.XLEN(64)) bus64 ();
  core_pipe_decode_imm_stage_if #(.XLEN(32)) bus32 ();

  assign bus64.flush     = flush;
  assign bus64.in_valid  = in_valid;
  assign bus64.in_instr  = in_instr;
  assign bus64.in_fmt    = in_fmt;
  assign bus64.out_ready = out_ready;
  assign bus32.flush     = flush;
  assign bus32.in_valid  = in_valid;
  assign bus32.in_instr  = in_instr;
  assign bus32.in_fmt    = in_fmt;
  assign bus32.out_ready = out_ready;

  core_pipe_decode_imm_stage #(.XLEN(64), .SKID_DEPTH(2)) dut64 (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus64)
  );

  core_pipe_decode_imm_stage #(.XLEN(32), .SKID_DEPTH(2)) dut32 (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus32)
  );

  // Free-running clock
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  function automatic longint unsigned fld(input logic [31:0] ins, input int hi, input int lo);
    longint unsigned x;
    x = {32'h0, ins};
    return (x >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
  endfunction

  function automatic longint unsigned sx(input longint unsigned val, input int w);
    if (((val >> (w - 1)) & 64'd1) != 0) return val - (64'd1 << w);
    return val;
  endfunction

  // Immediate decode computed from the field placement rules with plain arithmetic
  function automatic void ref_decode(input logic [31:0] ins, input int fmt, input int xlen,
                                     output logic [63:0] imm, output logic ill);
    longint unsigned v;
    v   = 0;
    ill = 1'b0;
    case (fmt)
      0:  v = sx(fld(ins, 31, 20), 12);
      1:  v = sx(fld(ins, 31, 25) * 32 + fld(ins, 11, 7), 12);
      2:  v = sx(fld(ins, 31, 31) * 4096 + fld(ins, 7, 7) * 2048 + fld(ins, 30, 25) * 32
                 + fld(ins, 11, 8) * 2, 13);
      3:  v = sx(fld(ins, 31, 12) * 4096, 32);
      4:  v = sx(fld(ins, 31, 31) * (1 << 20) + fld(ins, 19, 12) * 4096 + fld(ins, 20, 20) * 2048
                 + fld(ins, 30, 21) * 2, 21);
      5:  v = fld(ins, 19, 15);
      6:  begin
            v = sx(fld(ins, 12, 12) * 512 + fld(ins, 4, 3) * 128 + fld(ins, 5, 5) * 64
                   + fld(ins, 2, 2) * 32 + fld(ins, 6, 6) * 16, 10);
            ill = (v == 0);
          end
      7:  begin
            v = fld(ins, 10, 7) * 64 + fld(ins, 12, 11) * 16 + fld(ins, 5, 5) * 8 + fld(ins, 6, 6) * 4;
            ill = (v == 0);
          end
      8:  v = fld(ins, 5, 5) * 64 + fld(ins, 12, 10) * 8 + fld(ins, 6, 6) * 4;
      9:  v = sx(fld(ins, 12, 12) * 32 + fld(ins, 6, 2), 6);
      10: begin
            v = sx(fld(ins, 12, 12) * (1 << 17) + fld(ins, 6, 2) * 4096, 18);
            ill = (v == 0);
          end
      11: begin
            if (xlen == 64) v = fld(ins, 12, 12) * 32 + fld(ins, 6, 2);
            else begin
              v = fld(ins, 6, 2);
              ill = (fld(ins, 12, 12) != 0);
            end
          end
      12: v = fld(ins, 3, 2) * 64 + fld(ins, 12, 12) * 32 + fld(ins, 6, 4) * 4;
      13: v = fld(ins, 8, 7) * 64 + fld(ins, 12, 9) * 4;
      14: v = sx(fld(ins, 12, 12) * 2048 + fld(ins, 8, 8) * 1024 + fld(ins, 10, 9) * 256
                 + fld(ins, 6, 6) * 128 + fld(ins, 7, 7) * 64 + fld(ins, 2, 2) * 32
                 + fld(ins, 11, 11) * 16 + fld(ins, 5, 3) * 2, 12);
      15: v = sx(fld(ins, 12, 12) * 256 + fld(ins, 6, 5) * 64 + fld(ins, 2, 2) * 32
                 + fld(ins, 11, 10) * 8 + fld(ins, 4, 3) * 2, 9);
      16, 17, 18: begin
            if (xlen == 32) ill = 1'b1;
            else if (fmt == 16) v = fld(ins, 6, 5) * 64 + fld(ins, 12, 10) * 8;
            else if (fmt == 17) v = fld(ins, 4, 2) * 64 + fld(ins, 12, 12) * 32 + fld(ins, 6, 5) * 8;
            else v = fld(ins, 9, 7) * 64 + fld(ins, 12, 10) * 8;
          end
      default: ill = 1'b1;
    endcase
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    imm = v;
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compare both stages against the buffer model
  task automatic compareState();
    exp_entry_t h;
    checkOutput("in_ready64", bus64.in_ready, model_q.size() < 2);
    checkOutput("in_ready32", bus32.in_ready, model_q.size() < 2);
    checkOutput("out_valid64", bus64.out_valid, model_q.size() > 0);
    checkOutput("out_valid32", bus32.out_valid, model_q.size() > 0);
    if (model_q.size() > 0) begin
      h = model_q[0];
      checkOutput("out_imm64", bus64.out_imm, h.imm64);
      checkOutput("out_illegal64", bus64.out_illegal, h.ill64);
      checkOutput("out_fmt64", bus64.out_fmt, h.fmt);
      checkOutput("out_imm32", bus32.out_imm, h.imm32);
      checkOutput("out_illegal32", bus32.out_illegal, h.ill32);
      checkOutput("out_fmt32", bus32.out_fmt, h.fmt);
    end
  endtask

  // Drive one cycle of inputs from the falling edge, advance the model, then check
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [4:0] fmt,
                               input logic ordy, input logic fl, input logic rst,
                               output logic accepted);
    exp_entry_t e;
    logic       model_ready;
    in_valid  = v;
    in_instr  = ins;
    in_fmt    = fmt;
    out_ready = ordy;
    flush     = fl;
    g_reset   = rst;
    model_ready = (model_q.size() < 2);
    accepted  = 1'b0;
    #1;
    if (v && bus64.in_ready) dut_accepts++;
    if (bus64.out_valid) dut_out_cycles++;
    @(posedge g_clk);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      if (model_q.size() > 0 && ordy) void'(model_q.pop_front());
      if (v && model_ready) begin
        ref_decode(ins, int'(fmt), 64, e.imm64, e.ill64);
        ref_decode(ins, int'(fmt), 32, e.imm32, e.ill32);
        e.fmt = fmt;
        model_q.push_back(e);
        accepted = 1'b1;
      end
    end
    @(negedge g_clk);
    compareState();
  endtask

  // Push one vector through with the consumer ready and check the literal result
  task automatic checkDirected(input string tag, input logic [31:0] ins, input logic [4:0] fmt,
                               input logic [63:0] exp64, input logic ill64,
                               input logic [63:0] exp32, input logic ill32, input logic chk_imm32);
    logic acc;
    applyStimulus(1'b1, ins, fmt, 1'b1, 1'b0, 1'b0, acc);
    checkOutput({tag, "_valid"}, bus64.out_valid, 1'b1);
    checkOutput({tag, "_imm64"}, bus64.out_imm, exp64);
    checkOutput({tag, "_ill64"}, bus64.out_illegal, ill64);
    checkOutput({tag, "_ill32"}, bus32.out_illegal, ill32);
    if (chk_imm32) checkOutput({tag, "_imm32"}, bus32.out_imm, exp32);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, bus64.out_valid, 1'b0);
    checkOutput({tag, "_in_ready"}, bus64.in_ready, 1'b1);
    checkOutput({tag, "_out_imm"}, bus64.out_imm, 64'h0);
    checkOutput({tag, "_out_illegal"}, bus64.out_illegal, 1'b0);
    checkOutput({tag, "_out_fmt"}, bus64.out_fmt, 5'd0);
    checkOutput({tag, "_out_valid32"}, bus32.out_valid, 1'b0);
    checkOutput({tag, "_out_imm32"}, bus32.out_imm, 64'h0);
  endtask

  logic        acc;
  logic        got_third;
  logic [31:0] rnd_ins;
  logic [4:0]  rnd_fmt;

  // Directed scenarios followed by a randomized run
  initial begin
    g_reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_fmt = '0; out_ready = 1'b0;
    @(negedge g_clk);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, acc);
    checkZeroOutputs("reset");
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, acc);

    checkDirected("i_neg",     32'h8000_0013, 5'd0,  64'hFFFF_FFFF_FFFF_F800, 1'b0, 64'hFFFF_F800, 1'b0, 1'b1);
    checkDirected("u_neg",     32'h8000_0037, 5'd3,  64'hFFFF_FFFF_8000_0000, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
    checkDirected("u_pos",     32'h1234_5037, 5'd3,  64'h0000_0000_1234_5000, 1'b0, 64'h1234_5000, 1'b0, 1'b1);
    checkDirected("c_addi",    32'h0000_1FFD, 5'd9,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF, 1'b0, 1'b1);
    checkDirected("c_a4spn0",  32'h0000_0000, 5'd7,  64'h0, 1'b1, 64'h0, 1'b1, 1'b1);
    checkDirected("c_a16sp0",  32'h0000_0000, 5'd6,  64'h0, 1'b1, 64'h0, 1'b1, 1'b1);
    checkDirected("c_lui0",    32'h0000_0000, 5'd10, 64'h0, 1'b1, 64'h0, 1'b1, 1'b1);
    checkDirected("rsvd22",    32'hFFFF_FFFF, 5'd22, 64'h0, 1'b1, 64'h0, 1'b1, 1'b1);
    checkDirected("c_shamt32", 32'h0000_1002, 5'd11, 64'd32, 1'b0, 64'h0, 1'b1, 1'b0);
    checkDirected("c_lsd",     32'h0000_1C60, 5'd16, 64'hF8, 1'b0, 64'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, acc);

    // Backpressure: three offers against a stalled consumer
    dut_accepts = 0;
    applyStimulus(1'b1, 32'h0010_0093, 5'd0, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'h0020_0113, 5'd0, 1'b0, 1'b0, 1'b0, acc);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'h0030_0193, 5'd0, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("bp_accepts", dut_accepts, 2);
    checkOutput("bp_in_ready", bus64.in_ready, 1'b0);
    checkOutput("bp_head_imm", bus64.out_imm, 64'd1);
    got_third = 1'b0;
    for (int k = 0; k < 10 && !got_third; k++) begin
      applyStimulus(1'b1, 32'h0030_0193, 5'd0, 1'b1, 1'b0, 1'b0, acc);
      got_third = acc;
    end
    checkOutput("bp_third_accept", got_third, 1'b1);
    checkOutput("bp_accepts_total", dut_accepts, 3);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, acc);

    // Back-to-back throughput with the consumer always ready
    dut_accepts = 0;
    dut_out_cycles = 0;
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, $urandom, 5'($urandom_range(0, 18)), 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("b2b_accepts", dut_accepts, 8);
    checkOutput("b2b_out_cycles", dut_out_cycles, 8);

    // Flush with two entries buffered
    applyStimulus(1'b1, 32'h0040_0213, 5'd0, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'h0050_0293, 5'd0, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'h0060_0313, 5'd0, 1'b0, 1'b1, 1'b0, acc);
    checkOutput("flush_out_valid", bus64.out_valid, 1'b0);
    checkOutput("flush_in_ready", bus64.in_ready, 1'b1);
    // Flush coincident with an accepted input drops that input
    applyStimulus(1'b1, 32'h0070_0393, 5'd0, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'h0080_0413, 5'd0, 1'b1, 1'b1, 1'b0, acc);
    checkOutput("flush_drop_valid", bus64.out_valid, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("flush_drop_valid_late", bus64.out_valid, 1'b0);

    // Reset mid-stream with two entries buffered
    applyStimulus(1'b1, 32'hFFF0_0493, 5'd2, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'h8000_0537, 5'd3, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'h0000_1FFD, 5'd9, 1'b1, 1'b0, 1'b1, acc);
    checkZeroOutputs("midreset");
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, acc);

    // Randomized traffic, backpressure and occasional flushes
    for (int c = 0; c < 1500; c++) begin
      rnd_ins = $urandom;
      if ($urandom_range(0, 7) == 0) rnd_ins = 32'h0;
      else if ($urandom_range(0, 7) == 0) rnd_ins = rnd_ins & 32'h0000_1000;
      rnd_fmt = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
      applyStimulus($urandom_range(0, 9) < 7, rnd_ins, rnd_fmt, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 49) == 0, 1'b0, acc);
    end
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, acc);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/core_pipe_decode_imm_stage.md
Name: core_pipe_decode_imm_stage

Overview:
- Pipelined, parametrised immediate decoder stage for the decode pipeline.
- Takes one encoded instruction and a format select. Produces one XLEN-wide sign- or zero-extended immediate and an illegal-immediate flag.
- Adds valid/ready flow control, a 2-entry skid buffer, flush, and RV64 compressed formats.
- Sits between instruction fetch/align and the decode/dispatch register.

Parameters:
- XLEN, 64, datapath width; legal values 32 and 64. Immediates are sign- or zero-extended to XLEN.
- SKID_DEPTH, 2, buffer entries; legal values 1 and 2. With 1, the stage is a plain register and in_ready is out_ready combinationally.

Ports:
- g_clk  in  1  clock; all state updates on the rising edge.
- g_reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered entries this cycle.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  stage can accept input.
- in_instr  in  32  encoded instruction; 16-bit encodings occupy bits [15:0].
- in_fmt  in  5  immediate format select (encoding below).
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts output.
- out_imm  out  XLEN  decoded immediate.
- out_illegal  out  1  reserved or illegal immediate encoding.
- out_fmt  out  5  echo of in_fmt for the entry.

Behaviour:
- Format encoding:
  - 0 I, 1 S, 2 B, 3 U, 4 J: standard RV32/64 layouts, sign-extended from instr[31].
  - 5 CSR_ZIMM: zero-extended instr[19:15].
  - 6 C_ADDI16SP, 7 C_ADDI4SPN, 8 C_LSW, 9 C_ADDI, 10 C_LUI, 11 C_SHAMT, 12 C_LWSP, 13 C_SWSP, 14 C_J, 15 C_BZ: per the RVC spec.
  - 16 C_LSD: uimm[5:3]=instr[12:10], uimm[7:6]=instr[6:5].
  - 17 C_LDSP: uimm[5]=instr[12], uimm[4:3]=instr[6:5], uimm[8:6]=instr[4:2].
  - 18 C_SDSP: uimm[5:3]=instr[12:10], uimm[8:6]=instr[9:7].
  - 19..31: reserved.
- Extension width: U and C_LUI sign-extend from bit 31 and bit 17 respectively to full XLEN.
- C_SHAMT: shamt[5]=instr[12] when XLEN=64; zero-extended.
- out_illegal=1 when any of:
  - fmt is reserved; out_imm=0.
  - C_ADDI16SP, C_ADDI4SPN or C_LUI decode to an immediate of 0.
  - C_SHAMT with XLEN=32 and instr[12]=1.
  - fmt 16..18 with XLEN=32; out_imm=0.
  - In all other illegal cases out_imm holds the decoded value.
- Decode is combinational on the input side. The result is captured into the skid buffer on the input handshake (in_valid & in_ready). Latency is 1 cycle: accepted in cycle N, out_valid in cycle N+1.
- Buffer is a FIFO of SKID_DEPTH entries. Head drives out_*. It pops on out_valid & out_ready.
- in_ready is registered: in_ready = (count < SKID_DEPTH), so a push and pop in the same cycle keep count unchanged.
- Full throughput is 1 per cycle with out_ready held high. Order is strictly preserved.
- out_* must not change while out_valid=1 and out_ready=0.
- Flush: count becomes 0 next cycle and pending pushes that cycle are dropped. Flush has priority over any push or pop.
- Reset, including mid-operation: count=0, out_valid=0, in_ready=1, out_imm=0, out_illegal=0, out_fmt=0.
- Simultaneous push and pop when count=SKID_DEPTH cannot occur, because in_ready=0.
- Simultaneous push and pop when count=0: the entry is pushed, then appears next cycle.

Test Plan:
- XLEN=64, fmt=0, instr=0x80000013 -> out_imm=0xFFFFFFFFFFFFF800, illegal=0, one cycle after accept.
- XLEN=64, fmt=3, instr=0x80000037 -> 0xFFFFFFFF80000000; instr=0x12345037 -> 0x0000000012345000.
- XLEN=64, fmt=9, instr=0x1FFD -> 0xFFFFFFFFFFFFFFFF; fmt=7, instr=0x0000 -> illegal=1, imm=0; fmt=22 -> illegal=1, imm=0.
- fmt=11, instr=0x1002: XLEN=32 -> illegal=1; XLEN=64 -> imm=32, illegal=0.
- Backpressure, SKID_DEPTH=2, out_ready=0 while offering 3 instrs:
  - Only 2 are accepted and in_ready drops to 0.
  - out_* stay stable.
  - Raising out_ready drains the entries in order; the third is then accepted.
  - Back-to-back with out_ready=1 gives 1 result per cycle.
- Flush and reset with 2 entries buffered -> out_valid=0 and in_ready=1 next cycle. A flush coincident with in_valid drops that input. g_reset mid-stream gives all outputs 0.
